mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Handshake bundle between the EX/MEM latch, data memory and the MEM/WB latch.
interface mem_stage_if;
    logic         in_valid;
    logic [166:0] reg_ex_mem;
    logic         dmem_ready;
    logic [31:0]  drdata;
    logic         dmem_req;
    logic         dmem_we;
    logic [3:0]   dmem_be;
    logic [31:0]  daddr;
    logic [31:0]  dwdata;
    logic         stall;
    logic         mem_err;
    logic [166:0] reg_mem_wb;

    // Pipeline / memory side that drives the stage inputs
    modport master (
        output in_valid, reg_ex_mem, dmem_ready, drdata,
        input  dmem_req, dmem_we, dmem_be, daddr, dwdata, stall, mem_err, reg_mem_wb
    );

    // The memory stage itself
    modport slave (
        input  in_valid, reg_ex_mem, dmem_ready, drdata,
        output dmem_req, dmem_we, dmem_be, daddr, dwdata, stall, mem_err, reg_mem_wb
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores, waits on memory with a bounded
// timeout, flags misaligned accesses and fills the MEM/WB latch.
module mem_stage (
    input  logic          clk,
    input  logic          rst,
    mem_stage_if.slave    bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [1:0] size;      // 0 byte, 1 halfword, 2 word
    } dec_t;

    // Opcode decode for the memory ops; everything else is non-memory.
    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        case (op)
            6'b001010, 6'b001101: d = '{1'b1, 1'b0, 2'd0};
            6'b001011, 6'b001110: d = '{1'b1, 1'b0, 2'd1};
            6'b001100:            d = '{1'b1, 1'b0, 2'd2};
            6'b001111:            d = '{1'b0, 1'b1, 2'd0};
            6'b010000:            d = '{1'b0, 1'b1, 2'd1};
            6'b010001:            d = '{1'b0, 1'b1, 2'd2};
            default:              d = '{1'b0, 1'b0, 2'd0};
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return (a[0] == 1'b0);
            default: return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // MEM/WB layout: we, eff addr, opcode, alu_out (= eff addr), rdata, imm, pc
    function automatic logic [166:0] build_wb(input logic we, input logic [31:0] addr,
                                              input logic [5:0] op, input logic [31:0] rdata,
                                              input logic [31:0] imm, input logic [31:0] pc);
        return {we, addr, op, addr, rdata, imm, pc};
    endfunction

    state_t         state_r;
    logic [7:0]     wait_cnt_r;
    logic [134:0]   hold_r;      // {we, addr, op, sdata, imm, pc} of the pending request
    logic [166:0]   wb_r;
    logic           err_r;

    logic [134:0]   ex_pack_s;
    logic [134:0]   cur_s;
    dec_t           dec_s;
    logic           is_mem_s;
    logic           aligned_s;
    logic           issue_s;
    logic           timeout_s;
    logic           req_s;
    logic [166:0]   done_wb_s;
    logic [166:0]   nonmem_wb_s;
    logic [166:0]   misalign_wb_s;
    logic           unused_rsvd_s;

    assign ex_pack_s     = {bus.reg_ex_mem[166:96], bus.reg_ex_mem[63:0]};
    assign unused_rsvd_s = ^bus.reg_ex_mem[95:64];

    // Select live or held request, decode it and drive the memory port.
    always_comb begin
        cur_s     = (state_r == WAIT) ? hold_r : ex_pack_s;
        dec_s     = decode_op(cur_s[101:96]);
        is_mem_s  = dec_s.is_load | dec_s.is_store;
        aligned_s = is_aligned(dec_s.size, cur_s[103:102]);
        if (state_r == WAIT) begin
            issue_s = 1'b1;
        end else begin
            issue_s = bus.in_valid & is_mem_s & aligned_s;
        end
        timeout_s = (state_r == WAIT) && (wait_cnt_r == 8'hFF) && !bus.dmem_ready;
        req_s     = !rst && issue_s;

        bus.dmem_req = req_s;
        bus.stall    = req_s && !bus.dmem_ready && !timeout_s;
        if (req_s) begin
            bus.dmem_we = dec_s.is_store;
            bus.dmem_be = dec_s.is_store ? store_be(dec_s.size, cur_s[103:102]) : 4'b1111;
            bus.daddr   = {cur_s[133:104], 2'b00};
            bus.dwdata  = dec_s.is_store ? store_data(dec_s.size, cur_s[95:64]) : 32'h0;
        end else begin
            bus.dmem_we = 1'b0;
            bus.dmem_be = 4'b0000;
            bus.daddr   = 32'h0;
            bus.dwdata  = 32'h0;
        end

        done_wb_s     = build_wb(cur_s[134] & dec_s.is_load, cur_s[133:102], cur_s[101:96],
                                 dec_s.is_load ? bus.drdata : 32'h0, cur_s[63:32], cur_s[31:0]);
        nonmem_wb_s   = build_wb(cur_s[134], cur_s[133:102], cur_s[101:96], 32'h0,
                                 cur_s[63:32], cur_s[31:0]);
        misalign_wb_s = build_wb(1'b0, cur_s[133:102], cur_s[101:96], 32'h0,
                                 cur_s[63:32], cur_s[31:0]);
    end

    // Stage FSM: IDLE issues or passes through, WAIT holds the request until ready or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
            hold_r     <= '0;
            wb_r       <= '0;
            err_r      <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!bus.in_valid) begin
                        wb_r <= '0;
                    end else if (!is_mem_s) begin
                        wb_r <= nonmem_wb_s;
                    end else if (!aligned_s) begin
                        wb_r  <= misalign_wb_s;
                        err_r <= 1'b1;
                    end else if (bus.dmem_ready) begin
                        wb_r <= done_wb_s;
                    end else begin
                        hold_r     <= ex_pack_s;
                        wait_cnt_r <= 8'd0;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.dmem_ready) begin
                        wb_r    <= done_wb_s;
                        state_r <= IDLE;
                    end else if (wait_cnt_r == 8'hFF) begin
                        wb_r    <= '0;
                        err_r   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.reg_mem_wb = wb_r;
    assign bus.mem_err    = err_r;
endmodule
